// File: rtl/tile_cmd_issuer_if.sv
// Bundle of the job request, the 64-bit command channel and the completion return.
// The master side is the issuer; the slave side is the host/command consumer.
interface tile_cmd_issuer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DIM_WIDTH  = 12
);
    logic                  job_valid;
    logic                  job_ready;
    logic [ADDR_WIDTH-1:0] job_base_a;
    logic [ADDR_WIDTH-1:0] job_base_b;
    logic [ADDR_WIDTH-1:0] job_base_c;
    logic [ADDR_WIDTH-1:0] job_base_d;
    logic [DIM_WIDTH-1:0]  job_m;
    logic [DIM_WIDTH-1:0]  job_k;
    logic [DIM_WIDTH-1:0]  job_n;
    logic                  cmd_valid;
    logic [63:0]           cmd_data;
    logic                  cmd_ready;
    logic                  done_irq;
    logic                  job_busy;
    logic                  job_done;
    logic                  job_err;

    modport master (
        input  job_valid, job_base_a, job_base_b, job_base_c, job_base_d,
        input  job_m, job_k, job_n, cmd_ready, done_irq,
        output job_ready, cmd_valid, cmd_data, job_busy, job_done, job_err
    );

    modport slave (
        output job_valid, job_base_a, job_base_b, job_base_c, job_base_d,
        output job_m, job_k, job_n, cmd_ready, done_irq,
        input  job_ready, cmd_valid, cmd_data, job_busy, job_done, job_err
    );
endinterface

// File: rtl/tile_cmd_issuer.sv
// Splits one GEMM job into WxW tile commands with credit tracking on done_irq.
// Optional K-chaining across passes is enabled by defining TILE_ISSUER_KCHAIN_EN.
module tile_cmd_issuer #(
    parameter int ADDR_WIDTH           = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DIM_WIDTH            = 12,
    parameter int MAX_OUTSTANDING      = 4
) (
    input  logic              clk,
    input  logic              rst,
    tile_cmd_issuer_if.master bus
);
    localparam int W  = SYSTOLIC_ARRAY_WIDTH;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {IDLE, CALC, WAIT, ISSUE, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_a, base_b, base_c, base_d;
    logic [DIM_WIDTH-1:0]  dim_m, dim_k, dim_n;
    logic [DIM_WIDTH-1:0]  mt_total, kt_total, nt_total;
    logic [DIM_WIDTH-1:0]  mt, kt, nt;
    logic [OW-1:0]         outstanding, out_next;

    logic                  job_bad, handshake, credit_ret, stray, last_tile, must_wait;
    logic [ADDR_WIDTH-1:0] off_a, off_b, off_t;
    logic [ADDR_WIDTH-1:0] addr_a, addr_b, addr_c, addr_d;
    logic [31:0]           rem_m, rem_k, rem_n;
    logic [7:0]            len_m, len_k, len_n;

    function automatic logic [DIM_WIDTH-1:0] tiles(input logic [DIM_WIDTH-1:0] d);
        return DIM_WIDTH'((32'(d) + 32'(W - 1)) / 32'(W));
    endfunction

    always_comb begin
        job_bad = (bus.job_m == '0) || (bus.job_k == '0) || (bus.job_n == '0);
`ifndef TILE_ISSUER_KCHAIN_EN
        if (32'(bus.job_k) > 32'(W)) job_bad = 1'b1;
`endif
    end

    // Address offsets wrap modulo 2^ADDR_WIDTH, so truncating the products is exact.
    always_comb begin
        off_a  = ADDR_WIDTH'((32'(mt) * 32'(kt_total) + 32'(kt)) * 32'(W));
        off_b  = ADDR_WIDTH'((32'(kt) * 32'(nt_total) + 32'(nt)) * 32'(W));
        off_t  = ADDR_WIDTH'((32'(mt) * 32'(nt_total) + 32'(nt)) * 32'(W));
        addr_a = base_a + off_a;
        addr_b = base_b + off_b;
        addr_d = base_d + off_t;
`ifdef TILE_ISSUER_KCHAIN_EN
        addr_c = (kt == '0) ? base_c + off_t : base_d + off_t;
`else
        addr_c = base_c + off_t;
`endif
        rem_m  = 32'(dim_m) - 32'(mt) * 32'(W);
        rem_k  = 32'(dim_k) - 32'(kt) * 32'(W);
        rem_n  = 32'(dim_n) - 32'(nt) * 32'(W);
        len_m  = (rem_m > 32'(W)) ? 8'(W) : rem_m[7:0];
        len_k  = (rem_k > 32'(W)) ? 8'(W) : rem_k[7:0];
        len_n  = (rem_n > 32'(W)) ? 8'(W) : rem_n[7:0];
    end

    assign handshake  = (state == ISSUE) && bus.cmd_valid && bus.cmd_ready;
    assign credit_ret = bus.done_irq && (outstanding != '0);
    assign stray      = bus.done_irq && (outstanding == '0);
    assign last_tile  = (kt == kt_total - DIM_WIDTH'(1)) &&
                        (mt == mt_total - DIM_WIDTH'(1)) &&
                        (nt == nt_total - DIM_WIDTH'(1));

    // A later K pass reads D as its accumulator, so its first tile waits for all writes.
    always_comb begin
        must_wait = (outstanding == OW'(MAX_OUTSTANDING));
`ifdef TILE_ISSUER_KCHAIN_EN
        if ((kt != '0) && (mt == '0) && (nt == '0) && (outstanding != '0))
            must_wait = 1'b1;
`endif
    end

    always_comb begin
        out_next = outstanding;
        if (handshake && !credit_ret)
            out_next = outstanding + OW'(1);
        else if (!handshake && credit_ret)
            out_next = outstanding - OW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.job_ready <= 1'b1;
            bus.job_busy  <= 1'b0;
            bus.job_done  <= 1'b0;
            bus.job_err   <= 1'b0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_data  <= '0;
            outstanding   <= '0;
            base_a        <= '0;
            base_b        <= '0;
            base_c        <= '0;
            base_d        <= '0;
            dim_m         <= '0;
            dim_k         <= '0;
            dim_n         <= '0;
            mt_total      <= '0;
            kt_total      <= '0;
            nt_total      <= '0;
            mt            <= '0;
            kt            <= '0;
            nt            <= '0;
        end else begin
            bus.job_done <= 1'b0;
            bus.job_err  <= stray;
            outstanding  <= out_next;
            case (state)
                IDLE: begin
                    if (bus.job_valid && bus.job_ready) begin
                        base_a   <= bus.job_base_a;
                        base_b   <= bus.job_base_b;
                        base_c   <= bus.job_base_c;
                        base_d   <= bus.job_base_d;
                        dim_m    <= bus.job_m;
                        dim_k    <= bus.job_k;
                        dim_n    <= bus.job_n;
                        mt_total <= tiles(bus.job_m);
                        kt_total <= tiles(bus.job_k);
                        nt_total <= tiles(bus.job_n);
                        mt       <= '0;
                        kt       <= '0;
                        nt       <= '0;
                        if (job_bad) begin
                            bus.job_err <= 1'b1;
                        end else begin
                            state         <= CALC;
                            bus.job_ready <= 1'b0;
                            bus.job_busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    bus.cmd_data <= 64'({addr_d, addr_c, addr_b, addr_a, len_n, len_k, len_m});
                    if (must_wait) begin
                        state <= WAIT;
                    end else begin
                        state         <= ISSUE;
                        bus.cmd_valid <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!must_wait) begin
                        state         <= ISSUE;
                        bus.cmd_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.cmd_ready) begin
                        bus.cmd_valid <= 1'b0;
                        state         <= last_tile ? DRAIN : CALC;
                        // nt innermost, then mt, kt outermost
                        if (nt == nt_total - DIM_WIDTH'(1)) begin
                            nt <= '0;
                            if (mt == mt_total - DIM_WIDTH'(1)) begin
                                mt <= '0;
                                kt <= kt + DIM_WIDTH'(1);
                            end else begin
                                mt <= mt + DIM_WIDTH'(1);
                            end
                        end else begin
                            nt <= nt + DIM_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_next == '0) begin
                        state         <= IDLE;
                        bus.job_done  <= 1'b1;
                        bus.job_ready <= 1'b1;
                        bus.job_busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_cmd_issuer.sv
// Randomized bench for tile_cmd_issuer with a job-level reference model.
// Honours TILE_ISSUER_KCHAIN_EN the same way as the design.
module tb_tile_cmd_issuer;
    localparam int AW   = 10;
    localparam int W    = 16;
    localparam int DW   = 12;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tile_cmd_issuer_if #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW)) bus();

    tile_cmd_issuer #(
        .ADDR_WIDTH(AW), .SYSTOLIC_ARRAY_WIDTH(W), .DIM_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    bit          drain_q[$];
    int  tb_out, issued, total, lat_cnt, holdoff, holdoff_cfg;
    int  ready_pct, done_pct;
    bit  job_active, exp_done, exp_err, prev_hold;
    int  jm, jk, jn, jba, jbb, jbc, jbd;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Expected command list straight from the tiling rules; returns 1 for a rejected job.
    function automatic bit buildModel(input int m, input int k, input int n,
                                      input int ba, input int bb, input int bc, input int bd);
        int mtn, ktn, ntn, a, b, c, d, t, lm, lk, ln;
        longint word;
        exp_q.delete();
        drain_q.delete();
        if (m == 0 || k == 0 || n == 0) return 1'b1;
`ifndef TILE_ISSUER_KCHAIN_EN
        if (k > W) return 1'b1;
`endif
        mtn = (m + W - 1) / W;
        ktn = (k + W - 1) / W;
        ntn = (n + W - 1) / W;
        for (int kt = 0; kt < ktn; kt++)
            for (int mt = 0; mt < mtn; mt++)
                for (int nt = 0; nt < ntn; nt++) begin
                    t  = (mt * ntn + nt) * W;
                    a  = (ba + (mt * ktn + kt) * W) % (1 << AW);
                    b  = (bb + (kt * ntn + nt) * W) % (1 << AW);
                    d  = (bd + t) % (1 << AW);
                    c  = ((kt == 0 ? bc : bd) + t) % (1 << AW);
                    lm = (m - mt * W > W) ? W : m - mt * W;
                    lk = (k - kt * W > W) ? W : k - kt * W;
                    ln = (n - nt * W > W) ? W : n - nt * W;
                    word = longint'(lm) + (longint'(lk) << 8) + (longint'(ln) << 16)
                         + (longint'(a) << 24) + (longint'(b) << (24 + AW))
                         + (longint'(c) << (24 + 2 * AW)) + (longint'(d) << (24 + 3 * AW));
                    exp_q.push_back(word);
                    drain_q.push_back(kt > 0 && mt == 0 && nt == 0);
                end
        return 1'b0;
    endfunction

    task automatic clearModel();
        exp_q.delete();
        drain_q.delete();
        tb_out = 0; issued = 0; total = 0; lat_cnt = 0; holdoff = 0;
        job_active = 0; exp_done = 0; exp_err = 0; prev_hold = 0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        bus.job_valid = 0; bus.cmd_ready = 0; bus.done_irq = 0;
        bus.job_m = 0; bus.job_k = 0; bus.job_n = 0;
        bus.job_base_a = 0; bus.job_base_b = 0; bus.job_base_c = 0; bus.job_base_d = 0;
        @(negedge clk);
        checkOutput("rst_job_ready", bus.job_ready, 1);
        checkOutput("rst_job_busy", bus.job_busy, 0);
        checkOutput("rst_cmd_valid", bus.cmd_valid, 0);
        checkOutput("rst_job_done", bus.job_done, 0);
        checkOutput("rst_job_err", bus.job_err, 0);
        checkOutput("rst_cmd_data", bus.cmd_data, 0);
        @(negedge clk);
        rst = 1'b0;
        clearModel();
    endtask

    // One clock: check what the DUT shows now, then drive the inputs for the next edge.
    task automatic applyStimulus(input bit want_job, input bit force_stray);
        bit was_active, d, hs, bad;
        @(negedge clk);
        checkOutput("job_ready", bus.job_ready, !job_active);
        checkOutput("job_busy", bus.job_busy, job_active);
        checkOutput("job_done", bus.job_done, exp_done);
        checkOutput("job_err", bus.job_err, exp_err);
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) checkOutput("first_cmd_latency", bus.cmd_valid, 1);
        end
        if (prev_hold) checkOutput("valid_held", bus.cmd_valid, 1);
        if (bus.cmd_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_cmd", bus.cmd_valid, 0);
            end else begin
                checkOutput("cmd_data", bus.cmd_data, exp_q[0]);
                checkOutput("credit", tb_out < MAXO, 1);
                if (drain_q[0]) checkOutput("raw_drain", tb_out, 0);
            end
        end

        was_active = job_active;
        exp_done = 0;
        exp_err = 0;
        bus.cmd_ready = ($urandom_range(99) < ready_pct);
        d = 0;
        if (force_stray) begin
            d = 1;
        end else if (holdoff > 0) begin
            holdoff--;
            if (holdoff == 0) checkOutput("credit_stall", issued, (total < MAXO) ? total : MAXO);
        end else if (tb_out > 0 && $urandom_range(99) < done_pct) begin
            d = 1;
        end
        bus.done_irq = d;

        hs = bus.cmd_valid && bus.cmd_ready;
        if (d && tb_out == 0) exp_err = 1;
        if (hs && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(drain_q.pop_front());
            issued++;
        end
        tb_out = tb_out + (hs ? 1 : 0) - ((d && tb_out > 0) ? 1 : 0);
        prev_hold = bus.cmd_valid && !bus.cmd_ready;

        if (job_active && issued == total && tb_out == 0) begin
            exp_done = 1;
            job_active = 0;
        end

        if (want_job) begin
            bus.job_valid = 1;
            bus.job_m = DW'(jm); bus.job_k = DW'(jk); bus.job_n = DW'(jn);
            bus.job_base_a = AW'(jba); bus.job_base_b = AW'(jbb);
            bus.job_base_c = AW'(jbc); bus.job_base_d = AW'(jbd);
        end else if (was_active && $urandom_range(99) < 10) begin
            bus.job_valid = 1;
            bus.job_m = DW'($urandom_range(4095)); bus.job_k = DW'($urandom_range(4095));
            bus.job_n = DW'($urandom_range(4095));
            bus.job_base_a = AW'($urandom_range(1023));
        end else begin
            bus.job_valid = 0;
        end

        if (want_job && !was_active) begin
            bad = buildModel(jm, jk, jn, jba, jbb, jbc, jbd);
            if (bad) begin
                exp_err = 1;
            end else begin
                job_active = 1;
                issued = 0;
                total = exp_q.size();
                lat_cnt = 2;
                holdoff = holdoff_cfg;
            end
        end
    endtask

    task automatic runJob(input int m, input int k, input int n,
                          input int ba, input int bb, input int bc, input int bd);
        jm = m; jk = k; jn = n; jba = ba; jbb = bb; jbc = bc; jbd = bd;
        applyStimulus(1, 0);
        for (int c = 0; c < 4000 && job_active; c++) applyStimulus(0, 0);
        if (job_active) begin
            checkOutput("job_timeout", job_active, 0);
            resetDut();
        end
    endtask

    initial begin
        clearModel();
        ready_pct = 100; done_pct = 50; holdoff_cfg = 0;
        resetDut();

        runJob(16, 16, 16, 'h000, 'h100, 'h200, 'h300);
        runJob(20, 16, 16, 'h010, 'h120, 'h230, 'h340);

        ready_pct = 15;
        runJob(48, 16, 32, 'h3f0, 'h050, 'h123, 'h3e0);

        ready_pct = 100; done_pct = 60; holdoff_cfg = 20;
        runJob(96, 16, 16, 'h000, 'h100, 'h200, 'h300);
        holdoff_cfg = 0;

        done_pct = 40;
        runJob(16, 32, 16, 'h000, 'h100, 'h200, 'h300);

        runJob(16, 16, 0, 'h000, 'h100, 'h200, 'h300);
        applyStimulus(0, 1);
        applyStimulus(0, 0);

        for (int j = 0; j < 25; j++) begin
            int m, k, n;
            m = $urandom_range(70, 1);
            k = $urandom_range(40, 1);
            n = $urandom_range(70, 1);
            if ($urandom_range(19) == 0) m = 0;
            ready_pct = $urandom_range(100, 30);
            done_pct = $urandom_range(80, 20);
            runJob(m, k, n, $urandom_range(1023), $urandom_range(1023),
                   $urandom_range(1023), $urandom_range(1023));
        end

        ready_pct = 100; done_pct = 50;
        jm = 64; jk = 16; jn = 64; jba = 1; jbb = 2; jbc = 3; jbd = 4;
        applyStimulus(1, 0);
        repeat (5) applyStimulus(0, 0);
        resetDut();
        runJob(33, 9, 17, 'h200, 'h080, 'h040, 'h3ff);

        repeat (3) applyStimulus(0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
